// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that time-shares one 4:1 mux between four valid/ready requesters.
// The selected word is registered into a single output stage and tagged with its source index.
module mux4_rr_arbiter #(
  parameter int DW    = 8,
  parameter int BURST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req_valid,
  output logic [3:0]      req_ready,
  input  logic [4*DW-1:0] req_data,
  output logic [1:0]      sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_src,
  output logic            busy
);

  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state;
  logic [1:0]           last_grant;
  logic [CW-1:0]        beat_cnt;
  logic [3:0][DW-1:0]   lane_data;
  logic [1:0]           winner;
  logic [1:0]           idx;
  logic                 found;
  logic                 free;
  logic                 sel_valid;
  logic                 accept;

  assign lane_data = req_data;
  assign free      = !out_valid || out_ready;
  assign sel_valid = req_valid[sel];
  assign accept    = (state == GRANT) && sel_valid && free;
  assign busy      = (state == GRANT);

  // First set bit searching upward from last_grant+1, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == GRANT) req_ready[sel] = free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      last_grant <= 2'd3;
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            sel      <= winner;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Withdraw wins over stall; a stalled word stays put until out_ready.
          if (!sel_valid) begin
            state      <= IDLE;
            last_grant <= sel;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (beat_cnt == LAST_BEAT) begin
              state      <= IDLE;
              last_grant <= sel;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= lane_data[sel];
        out_src   <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 data mux between four valid/ready requesters.
- Drives the 2-bit mux select, registers the selected word into a single output stage, and tags each word with its source index.
- Sits in front of the existing 4:1 mux datapath so it can be time-shared safely.
- Supports optional burst hold: a grant is kept for up to BURST beats.

Parameters:
- DW, 8, data width per requester and of the output word.
- BURST, 1, maximum accepted beats per grant before arbitration reopens; legal range 1..16.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  4  per-requester valid; bit i belongs to requester i.
- req_ready  output  4  per-requester ready; at most one bit high.
- req_data  input  4*DW  packed data; requester i occupies bits [i*DW +: DW].
- sel  output  2  registered mux select, equal to the current or last grant index.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- out_data  output  DW  registered selected word.
- out_src  output  2  requester index of out_data.
- busy  output  1  high while state is GRANT.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; sel = 0; last_grant = 3, so requester 0 has first priority.
  - beat_cnt = 0; out_valid = 0; out_data = 0; out_src = 0; busy = 0; req_ready = 0.
- Reset mid-burst: an in-flight word is dropped and all state returns to the reset values immediately. No partial transfer survives.
- FSM states: IDLE and GRANT.
- IDLE:
  - If any req_valid bit is high, the winner is the first set bit searching upward and wrapping, starting at last_grant+1 mod 4.
  - On the clock edge: sel <= winner, beat_cnt <= 0, state <= GRANT.
  - If no req_valid bit is high, stay in IDLE. sel keeps its old value.
  - req_ready = 0 throughout IDLE.
- GRANT:
  - Output stage is free when out_valid == 0 or out_ready == 1.
  - req_ready[sel] = free. Every other req_ready bit is 0.
  - Accept = req_valid[sel] && free.
  - On accept: out_data <= req_data[sel slice], out_src <= sel, out_valid <= 1, beat_cnt <= beat_cnt + 1.
  - Release to IDLE with last_grant <= sel in two cases:
    - an accept while beat_cnt == BURST-1;
    - any cycle where req_valid[sel] == 0 (requester withdrew). No accept happens that cycle.
  - While the output stage is stalled (out_valid=1, out_ready=0), the grant is held and nothing is accepted. Stall does not count as a withdrawal if req_valid[sel] stays high.
- Output stage:
  - If out_ready=1 and there is no accept in the same cycle, out_valid <= 0.
  - If there is an accept in the same cycle, out_valid stays 1 and out_data is replaced. This gives full throughput: one word per cycle.
  - out_data and out_src are stable while out_valid=1 and out_ready=0.
- Latency:
  - A request first seen in IDLE at edge k gives the grant at edge k.
  - The first accept is at edge k+1, so out_valid is high after edge k+1. Minimum 2 cycles request-to-output.
  - Each re-arbitration costs one IDLE bubble cycle.
- Fairness: after a requester releases, it has the lowest priority in the next arbitration. With all four requesting continuously, the grant order is 0,1,2,3,0,...
- Simultaneous events:
  - A requester raising valid during another's grant waits.
  - A withdraw and a stall in the same cycle: withdraw wins and the FSM releases. The stalled output word is kept until out_ready.
- beat_cnt width: clog2(BURST)+1. It is never compared beyond BURST-1.

Test Plan:
- Single requester, BURST=1: req_valid=4'b0100, req_data slice 2=8'hA5, out_ready=1 -> sel=2 after one edge; out_data=8'hA5, out_src=2, out_valid=1 one edge later; then one IDLE bubble before the next beat.
- All four valid continuously, BURST=1, distinct data 8'h10/11/12/13 -> out_src sequence 0,1,2,3,0 with one idle cycle between words; req_ready one-hot or zero every cycle.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_src frozen, req_ready all 0; release out_ready -> next word accepted in the same cycle and out_valid stays 1.
- BURST=4, requester 1 valid with data 8'h01..8'h04, requester 3 also valid -> four consecutive out_src=1 words, then IDLE, then requester 3 granted.
- Withdraw: requester 0 granted, BURST=4, drops req_valid after 2 beats -> FSM returns to IDLE, last_grant=0, next winner is requester 1 if it is valid.
- Reset mid-burst: assert rst_n=0 between edges during GRANT -> out_valid, req_ready and busy go 0 immediately without waiting for clk; after release, requester 0 has first priority.
